// File: rtl/proc_pkg.sv
// Shared types and instruction field positions for the 10-bit bus processor controller.
package proc_pkg;

    typedef enum logic [2:0] {
        OP_LOAD = 3'd0,
        OP_MOV  = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_AND  = 3'd4,
        OP_XOR  = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } opcode_t;

    // Encoding doubles as the TIME output.
    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_t;

    typedef enum logic [1:0] {
        ALU_AND = 2'b00,
        ALU_XOR = 2'b01,
        ALU_ADD = 2'b10,
        ALU_SUB = 2'b11
    } alu_op_t;

    localparam int RX_LSB = 8;
    localparam int RY_LSB = 6;
    localparam int OP_LSB = 3;

    function automatic logic is_alu(input opcode_t op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_XOR};
    endfunction

endpackage

// File: rtl/proc_controller_rise_detect.sv
// Rising-edge detector: pulse is high in the cycle d is high after a registered low.
module rise_detect (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic pulse
);

    logic d_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign pulse = d & ~d_q;

endmodule

// File: rtl/proc_controller.sv
// Timestep sequencer and datapath control for the bus processor.
// Optional macro PROC_CTRL_STEP_EN adds a STEP input that gates advancement past T0.
module proc_controller
    import proc_pkg::*;
#(
    parameter int W = 10
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [W-1:0] DIN,
    input  logic         EXEC,
`ifdef PROC_CTRL_STEP_EN
    input  logic         STEP,
`endif
    output logic [W-1:0] IR,
    output logic [1:0]   TIME,
    output logic         DONE,
    output logic         BUSY,
    output logic         EXT_EN,
    output logic         RF_OE,
    output logic [1:0]   RF_RADDR,
    output logic         RF_WE,
    output logic [1:0]   RF_WADDR,
    output logic         A_LD,
    output logic         G_LD,
    output logic         G_OE,
    output logic [1:0]   ALU_OP
);

    tstep_t      state, state_next;
    logic        exec_rise;
    logic        adv;
    logic        ir_ld;
    logic        we, a_ld, g_ld;
    logic [1:0]  rx, ry;
    opcode_t     op;

    rise_detect u_exec_rise (
        .CLK   (CLK),
        .RST   (RST),
        .d     (EXEC),
        .pulse (exec_rise)
    );

`ifdef PROC_CTRL_STEP_EN
    rise_detect u_step_rise (
        .CLK   (CLK),
        .RST   (RST),
        .d     (STEP),
        .pulse (adv)
    );
`else
    assign adv = 1'b1;
`endif

    assign rx = IR[RX_LSB +: 2];
    assign ry = IR[RY_LSB +: 2];
    assign op = opcode_t'(IR[OP_LSB +: 3]);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= T0;
            IR    <= '0;
        end else begin
            state <= state_next;
            if (ir_ld) begin
                IR <= DIN;
            end
        end
    end

    // Exactly one bus driver per timestep; each write is paired with its driver.
    always_comb begin
        state_next = state;
        ir_ld      = 1'b0;
        EXT_EN     = 1'b0;
        RF_OE      = 1'b0;
        RF_RADDR   = 2'd0;
        we         = 1'b0;
        RF_WADDR   = 2'd0;
        a_ld       = 1'b0;
        g_ld       = 1'b0;
        G_OE       = 1'b0;
        ALU_OP     = ALU_AND;
        DONE       = 1'b0;
        case (state)
            T0: begin
                if (exec_rise) begin
                    ir_ld      = 1'b1;
                    state_next = T1;
                end
            end
            T1: begin
                if (is_alu(op)) begin
                    RF_OE    = 1'b1;
                    RF_RADDR = rx;
                    a_ld     = 1'b1;
                    if (adv) state_next = T2;
                end else begin
                    DONE = 1'b1;
                    if (adv) state_next = T0;
                    if (op == OP_LOAD) begin
                        EXT_EN   = 1'b1;
                        we       = 1'b1;
                        RF_WADDR = rx;
                    end else if (op == OP_MOV) begin
                        RF_OE    = 1'b1;
                        RF_RADDR = ry;
                        we       = 1'b1;
                        RF_WADDR = rx;
                    end
                end
            end
            T2: begin
                RF_OE    = 1'b1;
                RF_RADDR = ry;
                ALU_OP   = alu_op_t'(IR[OP_LSB +: 2]);
                g_ld     = 1'b1;
                if (adv) state_next = T3;
            end
            T3: begin
                G_OE     = 1'b1;
                we       = 1'b1;
                RF_WADDR = rx;
                DONE     = 1'b1;
                if (adv) state_next = T0;
            end
            default: state_next = T0;
        endcase
    end

    // Loads fire only on the advancing cycle so a STEP hold never rewrites.
    assign RF_WE = we & adv;
    assign A_LD  = a_ld & adv;
    assign G_LD  = g_ld & adv;
    assign TIME  = state;
    assign BUSY  = (state != T0);

endmodule

// File: tb/tb_proc_controller.sv
// Self-checking bench for proc_controller: directed vector table, corner sequences, random run.
module tb_proc_controller;

    typedef logic [25:0] out_t;

    typedef struct {
        logic [9:0]  din;
        logic        exec;
        logic [9:0]  ir;
        logic [15:0] ctl;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] din;
    logic       exec;
`ifdef PROC_CTRL_STEP_EN
    logic       step = 1'b0;
`endif
    logic [9:0] ir_o;
    logic [1:0] time_o, rf_raddr, rf_waddr, alu_op;
    logic       done, busy, ext_en, rf_oe, rf_we, a_ld, g_ld, g_oe;
    out_t       dut_out;

    int         n_tests = 0;
    int         n_fail  = 0;
    out_t       exp_q[$];
    vec_t       vecs[$];

    proc_controller #(.W(10)) dut (
        .CLK      (clk),
        .RST      (rst),
        .DIN      (din),
        .EXEC     (exec),
`ifdef PROC_CTRL_STEP_EN
        .STEP     (step),
`endif
        .IR       (ir_o),
        .TIME     (time_o),
        .DONE     (done),
        .BUSY     (busy),
        .EXT_EN   (ext_en),
        .RF_OE    (rf_oe),
        .RF_RADDR (rf_raddr),
        .RF_WE    (rf_we),
        .RF_WADDR (rf_waddr),
        .A_LD     (a_ld),
        .G_LD     (g_ld),
        .G_OE     (g_oe),
        .ALU_OP   (alu_op)
    );

    always #5 clk = ~clk;

    assign dut_out = {ir_o, ext_en, rf_oe, rf_raddr, rf_we, rf_waddr, a_ld, g_ld, g_oe,
                      alu_op, done, busy, time_o};

    function automatic logic [15:0] mk(input logic ext, input logic rfoe, input logic [1:0] ra,
                                       input logic we, input logic [1:0] wa, input logic ald,
                                       input logic gld, input logic goe, input logic [1:0] aop,
                                       input logic dn, input logic [1:0] tm);
        return {ext, rfoe, ra, we, wa, ald, gld, goe, aop, dn, (tm != 2'd0), tm};
    endfunction

    // Reference controls for a given timestep and instruction word.
    function automatic logic [15:0] model_ctl(input logic [1:0] st, input logic [9:0] ir);
        logic [1:0] rx, ry;
        logic [2:0] op;
        rx = ir[9:8];
        ry = ir[7:6];
        op = ir[5:3];
        case (st)
            2'd1: begin
                if (op == 3'd0)      return mk(1, 0, 0,  1, rx, 0, 0, 0, 0, 1, 1);
                else if (op == 3'd1) return mk(0, 1, ry, 1, rx, 0, 0, 0, 0, 1, 1);
                else if (op <= 3'd5) return mk(0, 1, rx, 0, 0,  1, 0, 0, 0, 0, 1);
                else                 return mk(0, 0, 0,  0, 0,  0, 0, 0, 0, 1, 1);
            end
            2'd2:    return mk(0, 1, ry, 0, 0, 0, 1, 0, op[1:0], 0, 2);
            2'd3:    return mk(0, 0, 0, 1, rx, 0, 0, 1, 0, 1, 3);
            default: return 16'h0000;
        endcase
    endfunction

    function automatic void check(input string nm, input out_t got, input out_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endfunction

    function automatic void add_vec(input logic [9:0] d, input logic e, input logic [9:0] ir,
                                    input logic [15:0] ctl);
        vec_t v;
        v.din  = d;
        v.exec = e;
        v.ir   = ir;
        v.ctl  = ctl;
        vecs.push_back(v);
    endfunction

    // Called at a falling edge: drive, queue expectation, compare after the next rising edge.
    task automatic apply(input logic [9:0] d, input logic e, input out_t exp, input string nm);
        din  = d;
        exec = e;
        exp_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        check(nm, dut_out, exp_q.pop_front());
    endtask

    initial begin
        logic [1:0] m_st;
        logic [9:0] m_ir;
        logic       m_eq;
        logic       e;
        logic [9:0] d;
        int         done_cnt;
        logic       exp_done;

        rst  = 1'b1;
        din  = 10'h000;
        exec = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_state", dut_out, 26'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", dut_out, 26'h0);

`ifndef PROC_CTRL_STEP_EN
        // din, exec, expected IR, expected controls after the following edge
        add_vec(10'h200, 1, 10'h200, mk(1, 0, 0, 1, 2, 0, 0, 0, 0, 1, 1)); // LOAD R2
        add_vec(10'h3FF, 0, 10'h200, 16'h0);
        add_vec(10'h1D0, 1, 10'h1D0, mk(0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 1)); // ADD R1,R3
        add_vec(10'h000, 1, 10'h1D0, mk(0, 1, 3, 0, 0, 0, 1, 0, 2, 0, 2));
        add_vec(10'h000, 1, 10'h1D0, mk(0, 0, 0, 1, 1, 0, 0, 1, 0, 1, 3));
        add_vec(10'h000, 1, 10'h1D0, 16'h0);                                // held: no restart
        add_vec(10'h000, 0, 10'h1D0, 16'h0);
        add_vec(10'h2F8, 1, 10'h2F8, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1)); // opcode 111
        add_vec(10'h000, 0, 10'h2F8, 16'h0);
        add_vec(10'h348, 1, 10'h348, mk(0, 1, 1, 1, 3, 0, 0, 0, 0, 1, 1)); // MOV R3,R1
        add_vec(10'h000, 0, 10'h348, 16'h0);
        add_vec(10'h098, 1, 10'h098, mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1)); // SUB R0,R2
        add_vec(10'h000, 0, 10'h098, mk(0, 1, 2, 0, 0, 0, 1, 0, 3, 0, 2));
        add_vec(10'h3FF, 1, 10'h098, mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 3)); // rise in T2 dropped
        add_vec(10'h3FF, 1, 10'h098, 16'h0);
        add_vec(10'h000, 0, 10'h098, 16'h0);
        add_vec(10'h1A0, 1, 10'h1A0, mk(0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 1)); // AND R1,R2
        add_vec(10'h000, 0, 10'h1A0, mk(0, 1, 2, 0, 0, 0, 1, 0, 0, 0, 2));
        add_vec(10'h000, 0, 10'h1A0, mk(0, 0, 0, 1, 1, 0, 0, 1, 0, 1, 3));
        add_vec(10'h000, 0, 10'h1A0, 16'h0);
        add_vec(10'h2E8, 1, 10'h2E8, mk(0, 1, 2, 0, 0, 1, 0, 0, 0, 0, 1)); // XOR R2,R3
        add_vec(10'h000, 0, 10'h2E8, mk(0, 1, 3, 0, 0, 0, 1, 0, 1, 0, 2));
        add_vec(10'h000, 0, 10'h2E8, mk(0, 0, 0, 1, 2, 0, 0, 1, 0, 1, 3));
        add_vec(10'h000, 0, 10'h2E8, 16'h0);
        add_vec(10'h030, 1, 10'h030, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1)); // opcode 110
        add_vec(10'h000, 0, 10'h030, 16'h0);

        foreach (vecs[i]) begin
            apply(vecs[i].din, vecs[i].exec, {vecs[i].ir, vecs[i].ctl}, $sformatf("vec%0d", i));
        end

        // EXEC held high for 20 cycles starts exactly one MOV.
        din      = 10'h348;
        exec     = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) done_cnt++;
        end
        exec = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("held_exec_done_count", 26'(done_cnt), 26'd1);

        // Reset during T2 of ADD aborts with no later write.
        apply(10'h1D0, 1, {10'h1D0, mk(0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 1)}, "pre_rst_t1");
        apply(10'h000, 0, {10'h1D0, mk(0, 1, 3, 0, 0, 0, 1, 0, 2, 0, 2)}, "pre_rst_t2");
        #1 rst = 1'b1;
        #1 check("rst_mid_t2_outputs", dut_out, 26'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("post_rst_no_we%0d", i), {24'h0, rf_we, busy}, 26'h0);
        end

        // Random instructions and EXEC against the bench model plus invariants.
        m_st = 2'd0;
        m_ir = 10'h000;
        m_eq = 1'b0;
        for (int i = 0; i < 400; i++) begin
            e = 1'($urandom_range(0, 1));
            d = 10'($urandom_range(0, 1023));
            case (m_st)
                2'd0: if (e && !m_eq) begin m_ir = d; m_st = 2'd1; end
                2'd1: m_st = (m_ir[5:3] inside {3'd2, 3'd3, 3'd4, 3'd5}) ? 2'd2 : 2'd0;
                2'd2: m_st = 2'd3;
                default: m_st = 2'd0;
            endcase
            m_eq = e;
            apply(d, e, {m_ir, model_ctl(m_st, m_ir)}, "rand");
            check("bus_onehot0", 26'($onehot0({ext_en, rf_oe, g_oe})), 26'd1);
            exp_done = (time_o == 2'd3) ||
                       (time_o == 2'd1 && !(ir_o[5:3] inside {3'd2, 3'd3, 3'd4, 3'd5}));
            check("done_final_step", 26'(done), 26'(exp_done));
        end
`else
        // SUB with STEP idle: hold in T1, A_LD only on the STEP rise.
        apply(10'h098, 1, {10'h098, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1)}, "step_t1");
        exec = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("step_hold%0d", i), dut_out,
                  {10'h098, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1)});
        end
        step = 1'b1;
        #1 check("step_rise_a_ld", dut_out, {10'h098, mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1)});
        @(negedge clk);
        check("step_advanced_t2", dut_out, {10'h098, mk(0, 1, 2, 0, 0, 0, 0, 0, 3, 0, 2)});
        step = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
